// File: rtl/vram_copy_arbiter.sv
// Single-port VRAM arbiter: display reads win, ROM-to-VRAM copy fills idle cycles.
// Optional stall counter port enabled by VRAM_ARB_STALL_CNT_EN.
module vram_copy_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8,
    parameter int WORDS  = 2048
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_ad,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_ad,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    output logic              vram_ce,
    output logic              vram_wre,
    output logic [ADDR_W-1:0] vram_ad,
    output logic [DATA_W-1:0] vram_wdata,
    input  logic [DATA_W-1:0] vram_rdata
`ifdef VRAM_ARB_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_disp_valid;

    logic w_start_ok;
    logic w_wr;
    logic w_last;

    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_wr       = (r_state == S_WR) && !disp_req;
    assign w_last     = (r_cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_wdata      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_disp_valid <= 1'b0;
        end else begin
            r_disp_valid <= disp_req;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_cnt   <= '0;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_RD;
                    end
                end
                S_RD: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_wdata <= rom_data;
                    r_state <= S_WR;
                end
                S_WR: begin
                    // A display request holds the pending word here untouched
                    if (!disp_req) begin
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_state <= S_RD;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef VRAM_ARB_STALL_CNT_EN
    logic [15:0] r_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall <= '0;
        end else if (w_start_ok) begin
            r_stall <= '0;
        end else if ((r_state == S_WR) && disp_req && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign stall_cnt = r_stall;
`else
    logic w_unused;
    assign w_unused = w_start_ok;
`endif

    assign busy       = r_busy;
    assign done       = r_done;
    assign rom_ad     = r_cnt;
    assign disp_valid = r_disp_valid;
    assign disp_data  = vram_rdata;
    assign vram_ce    = disp_req || w_wr;
    assign vram_wre   = w_wr;
    assign vram_ad    = disp_req ? disp_ad : r_cnt;
    assign vram_wdata = r_wdata;

endmodule

// File: tb/tb_vram_copy_arbiter.sv
// Bench for vram_copy_arbiter: small 8-word instance and a full 2048-word instance,
// each with behavioural ROM and VRAM models.
module tb_vram_copy_arbiter;

    localparam int AW  = 11;
    localparam int DW  = 8;
    localparam int NA  = 8;
    localparam int NB  = 2048;
    localparam int MEM = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a, start_a, busy_a, done_a, dreq_a, dval_a, ce_a, wre_a;
    logic [AW-1:0] rom_ad_a, dad_a, ad_a;
    logic [DW-1:0] rom_q_a, ddata_a, wd_a;
    logic [DW-1:0] rd_a = '0;
    logic          rst_b, start_b, busy_b, done_b, dreq_b, dval_b, ce_b, wre_b;
    logic [AW-1:0] rom_ad_b, dad_b, ad_b;
    logic [DW-1:0] rom_q_b, ddata_b, wd_b;
    logic [DW-1:0] rd_b = '0;
`ifdef VRAM_ARB_STALL_CNT_EN
    logic [15:0]   stall_a, stall_b;
`endif

    logic [DW-1:0] rom_a  [MEM];
    logic [DW-1:0] rom_b  [MEM];
    logic [DW-1:0] vram_a [MEM] = '{default: 8'hA5};
    logic [DW-1:0] vram_b [MEM] = '{default: 8'hA5};

    int            cyc = 0;
    int            busy_cnt_a = 0, wr_cnt_a = 0, bad_a = 0, last_cyc_a = 0;
    int            busy_cnt_b = 0, wr_cnt_b = 0, bad_b = 0, last_cyc_b = 0;
    logic [AW-1:0] last_ad_a = '0, last_ad_b = '0;

    int checks   = 0;
    int failures = 0;

    vram_copy_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WORDS(NA)) u_a (
        .clk(clk), .reset(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
        .rom_ad(rom_ad_a), .rom_data(rom_q_a), .disp_req(dreq_a), .disp_ad(dad_a),
        .disp_valid(dval_a), .disp_data(ddata_a), .vram_ce(ce_a), .vram_wre(wre_a),
        .vram_ad(ad_a), .vram_wdata(wd_a), .vram_rdata(rd_a)
`ifdef VRAM_ARB_STALL_CNT_EN
        , .stall_cnt(stall_a)
`endif
    );

    vram_copy_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WORDS(NB)) u_b (
        .clk(clk), .reset(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
        .rom_ad(rom_ad_b), .rom_data(rom_q_b), .disp_req(dreq_b), .disp_ad(dad_b),
        .disp_valid(dval_b), .disp_data(ddata_b), .vram_ce(ce_b), .vram_wre(wre_b),
        .vram_ad(ad_b), .vram_wdata(wd_b), .vram_rdata(rd_b)
`ifdef VRAM_ARB_STALL_CNT_EN
        , .stall_cnt(stall_b)
`endif
    );

    // ROM / VRAM models and activity monitors
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (busy_a) busy_cnt_a = busy_cnt_a + 1;
        if (busy_b) busy_cnt_b = busy_cnt_b + 1;
        if (dreq_a && wre_a) bad_a = bad_a + 1;
        if (dreq_b && wre_b) bad_b = bad_b + 1;
        rom_q_a <= rom_a[rom_ad_a];
        rom_q_b <= rom_b[rom_ad_b];
        if (ce_a && wre_a) begin
            vram_a[ad_a] = wd_a;
            wr_cnt_a     = wr_cnt_a + 1;
            last_ad_a    = ad_a;
            last_cyc_a   = cyc;
        end else if (ce_a) begin
            rd_a <= vram_a[ad_a];
        end
        if (ce_b && wre_b) begin
            vram_b[ad_b] = wd_b;
            wr_cnt_b     = wr_cnt_b + 1;
            last_ad_b    = ad_b;
            last_cyc_b   = cyc;
        end else if (ce_b) begin
            rd_b <= vram_b[ad_b];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic pulse_b();
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
    endtask

    task automatic wait_done_a(input int budget);
        int n = 0;
        while (!done_a && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("a_done_timeout", 32'(done_a), 32'd1);
    endtask

    task automatic wait_done_b(input int budget);
        int n = 0;
        while (!done_b && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("b_done_timeout", 32'(done_b), 32'd1);
    endtask

    initial begin
        int            b0, w0, bd0, n, bad_words;
        logic          pend;
        logic [DW-1:0] exp;
        logic [DW-1:0] old [NA];

        rst_a = 1'b1; rst_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        dreq_a = 1'b0; dreq_b = 1'b0;
        dad_a = '0; dad_b = '0;
        for (int i = 0; i < MEM; i++) begin
            rom_a[i] = 8'(i + 16);
            rom_b[i] = 8'($urandom);
        end
        negs(3);

        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_dval", 32'(dval_a), 32'd0);
        chk("rst_ce", 32'(ce_a), 32'd0);
        chk("rst_wre", 32'(wre_a), 32'd0);
`ifdef VRAM_ARB_STALL_CNT_EN
        chk("rst_stall", 32'(stall_a), 32'd0);
`endif
        rst_a = 1'b0; rst_b = 1'b0;
        negs(1);

        // plain copy of i+0x10
        b0 = busy_cnt_a; w0 = wr_cnt_a;
        pulse_a();
        wait_done_a(100);
        chk("t1_busy_cycles", 32'(busy_cnt_a - b0), 32'd24);
        chk("t1_writes", 32'(wr_cnt_a - w0), 32'd8);
        chk("t1_last_addr", 32'(last_ad_a), 32'd7);
        chk("t1_done_latency", 32'(cyc), 32'(last_cyc_a));
        for (int i = 0; i < NA; i++) chk("t1_vram", 32'(vram_a[i]), 32'(8'(i + 16)));
        chk("t1_vram8_untouched", 32'(vram_a[8]), 32'h A5);

        // display stall of 4 cycles during WR of word 2
        for (int i = 0; i < NA; i++) rom_a[i] = 8'($urandom);
        b0 = busy_cnt_a; w0 = wr_cnt_a; bd0 = bad_a;
        pulse_a();
        chk("t2_done_drop", 32'(done_a), 32'd0);
        chk("t2_busy", 32'(busy_a), 32'd1);
        negs(8);
        chk("t2_dval_idle", 32'(dval_a), 32'd0);
        dreq_a = 1'b1; dad_a = 11'd5;
        exp = vram_a[5];
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t2_dval", 32'(dval_a), 32'd1);
            chk("t2_ddata", 32'(ddata_a), 32'(exp));
        end
        dreq_a = 1'b0;
        @(negedge clk);
        chk("t2_dval_end", 32'(dval_a), 32'd0);
        wait_done_a(100);
        chk("t2_busy_cycles", 32'(busy_cnt_a - b0), 32'd28);
        chk("t2_writes", 32'(wr_cnt_a - w0), 32'd8);
        chk("t2_no_wr_on_req", 32'(bad_a - bd0), 32'd0);
`ifdef VRAM_ARB_STALL_CNT_EN
        chk("t2_stall_cnt", 32'(stall_a), 32'd4);
`endif
        for (int i = 0; i < NA; i++) chk("t2_vram", 32'(vram_a[i]), 32'(rom_a[i]));

        // start while busy at cnt=3 is ignored
        for (int i = 0; i < NA; i++) rom_a[i] = 8'($urandom);
        b0 = busy_cnt_a; w0 = wr_cnt_a;
        pulse_a();
`ifdef VRAM_ARB_STALL_CNT_EN
        chk("t3_stall_clr", 32'(stall_a), 32'd0);
`endif
        negs(9);
        pulse_a();
        wait_done_a(100);
        chk("t3_busy_cycles", 32'(busy_cnt_a - b0), 32'd24);
        chk("t3_writes", 32'(wr_cnt_a - w0), 32'd8);
        for (int i = 0; i < NA; i++) chk("t3_vram", 32'(vram_a[i]), 32'(rom_a[i]));

        // reset while word 4 waits on ROM data
        for (int i = 0; i < NA; i++) begin
            old[i]   = vram_a[i];
            rom_a[i] = old[i] ^ 8'($urandom_range(1, 255));
        end
        w0 = wr_cnt_a;
        pulse_a();
        negs(13);
        rst_a = 1'b1;
        #1;
        chk("t4_busy_rst", 32'(busy_a), 32'd0);
        chk("t4_done_rst", 32'(done_a), 32'd0);
        @(negedge clk);
        chk("t4_writes", 32'(wr_cnt_a - w0), 32'd4);
        for (int i = 0; i < 4; i++) chk("t4_vram_done", 32'(vram_a[i]), 32'(rom_a[i]));
        for (int i = 4; i < NA; i++) chk("t4_vram_kept", 32'(vram_a[i]), 32'(old[i]));
        rst_a = 1'b0;
        @(negedge clk);
        pulse_a();
        wait_done_a(100);
        for (int i = 0; i < NA; i++) chk("t4_recopy", 32'(vram_a[i]), 32'(rom_a[i]));

        // full address space copy
        b0 = busy_cnt_b; w0 = wr_cnt_b;
        pulse_b();
        wait_done_b(7000);
        chk("t5_busy_cycles", 32'(busy_cnt_b - b0), 32'd6144);
        chk("t5_writes", 32'(wr_cnt_b - w0), 32'd2048);
        chk("t5_last_addr", 32'(last_ad_b), 32'd2047);
        chk("t5_done_latency", 32'(cyc), 32'(last_cyc_b));
        bad_words = 0;
        for (int i = 0; i < NB; i++) if (vram_b[i] !== rom_b[i]) bad_words++;
        chk("t5_vram_words", 32'(bad_words), 32'd0);
        chk("t5_vram_first", 32'(vram_b[0]), 32'(rom_b[0]));
        chk("t5_vram_last", 32'(vram_b[NB-1]), 32'(rom_b[NB-1]));

        // restart from DONE under random display traffic
        for (int i = 0; i < NB; i++) rom_b[i] = 8'($urandom);
        b0 = busy_cnt_b; w0 = wr_cnt_b; bd0 = bad_b;
        pulse_b();
        chk("t5b_done_drop", 32'(done_b), 32'd0);
        chk("t5b_busy", 32'(busy_b), 32'd1);
        pend = 1'b0; exp = '0; n = 0;
        while (n < 20000) begin
            if (pend) begin
                chk("t5b_dval", 32'(dval_b), 32'd1);
                chk("t5b_ddata", 32'(ddata_b), 32'(exp));
            end else begin
                chk("t5b_dval_idle", 32'(dval_b), 32'd0);
            end
            if (done_b) break;
            dreq_b = ($urandom_range(0, 3) == 0);
            dad_b  = AW'($urandom);
            exp    = vram_b[dad_b];
            pend   = dreq_b;
            @(negedge clk);
            n++;
        end
        dreq_b = 1'b0;
        chk("t5b_done_timeout", 32'(done_b), 32'd1);
        chk("t5b_writes", 32'(wr_cnt_b - w0), 32'd2048);
        chk("t5b_no_wr_on_req", 32'(bad_b - bd0), 32'd0);
`ifdef VRAM_ARB_STALL_CNT_EN
        chk("t5b_stall_cnt", 32'(stall_b), 32'(busy_cnt_b - b0 - 6144));
`endif
        bad_words = 0;
        for (int i = 0; i < NB; i++) if (vram_b[i] !== rom_b[i]) bad_words++;
        chk("t5b_vram_words", 32'(bad_words), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
